weight_stream_mem: RTL and testbench

Parametrised multi-neuron weight store for one ELM hidden layer. It holds `numWeight` weights for each of `numNeurons` neurons in per-neuron block RAM banks. Weights are loaded at run time through a write port, replacing the static initialisation file. On a `start` pulse it streams every neuron's weight vector in lock-step, one input index per enabled cycle, to the parallel MAC array.

---
 rtl/weight_stream_mem.sv | 174 +++++++++++++++++
 tb/tb_weight_stream_mem.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_mem.sv
// weight_stream_mem
// Run-time loadable weight store for one ELM hidden layer. Each of numNeurons
// banks holds numWeight weights, written sequentially through a per-bank write
// pointer. A start pulse streams all banks in lock-step, one index per ren
// cycle, with one cycle of read latency.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   wen, wneuron,     write strobe, target bank, weight value
//   wdata
//   load_clr          clear write pointers, loaded and load_err
//   start, ren        begin a read pass, advance enable during the pass
//   wout              neuron n at bits [n*dataWidth +: dataWidth]
//   wout_valid        wout holds a new index
//   wout_last         qualifies the final index
//   busy              a pass is in progress
//   loaded            every bank holds numWeight weights
//   load_err          sticky error (dropped write or start while not loaded)

module weight_stream_mem #(
    parameter int unsigned numNeurons   = 4,
    parameter int unsigned numWeight    = 784,
    parameter int unsigned addressWidth = 10,
    parameter int unsigned dataWidth    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wen,
    input  logic [5:0]                      wneuron,
    input  logic [dataWidth-1:0]            wdata,
    input  logic                            load_clr,
    input  logic                            start,
    input  logic                            ren,
    output logic [numNeurons*dataWidth-1:0] wout,
    output logic                            wout_valid,
    output logic                            wout_last,
    output logic                            busy,
    output logic                            loaded,
    output logic                            load_err
);

    localparam int unsigned              Depth      = 1 << addressWidth;
    localparam logic [addressWidth:0]    NumWeightW = (addressWidth + 1)'(numWeight);
    localparam logic [addressWidth-1:0]  LastAddr   = addressWidth'(numWeight - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [addressWidth-1:0] raddr_q, raddr_d;
    logic [addressWidth:0]   wptr_q [numNeurons];
    logic [addressWidth:0]   wptr_d [numNeurons];
    logic [numNeurons-1:0]   bank_we;
    logic                    loaded_q, loaded_d;
    logic                    err_q, err_d;
    logic                    valid_q, last_q;
    logic                    rd_issue, start_err, wr_err;
    logic                    tgt_ok, tgt_full;

    assign busy       = (state_q != StIdle);
    assign loaded     = loaded_q;
    assign load_err   = err_q;
    assign wout_valid = valid_q;
    assign wout_last  = last_q;

    // Read sequencer
    always_comb begin
        state_d   = state_q;
        raddr_d   = raddr_q;
        rd_issue  = 1'b0;
        start_err = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (loaded_q) begin
                        state_d = StRun;
                        raddr_d = '0;
                    end else begin
                        start_err = 1'b1;
                    end
                end
            end
            StRun: begin
                if (ren) begin
                    rd_issue = 1'b1;
                    if (raddr_q == LastAddr) begin
                        state_d = StDrain;
                    end else begin
                        raddr_d = raddr_q + 1'b1;
                    end
                end
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Write pointers, loaded and error flags; load_clr overrides any write
    always_comb begin
        tgt_ok   = 1'b0;
        tgt_full = 1'b0;
        for (int n = 0; n < numNeurons; n++) begin
            if (wneuron == 6'(n)) begin
                tgt_ok   = 1'b1;
                tgt_full = (wptr_q[n] >= NumWeightW);
            end
        end
        wr_err   = wen && !load_clr && (busy || !tgt_ok || tgt_full);
        loaded_d = 1'b1;
        for (int n = 0; n < numNeurons; n++) begin
            bank_we[n] = wen && !load_clr && !busy && (wneuron == 6'(n)) &&
                         (wptr_q[n] < NumWeightW);
            if (load_clr) begin
                wptr_d[n] = '0;
            end else if (bank_we[n]) begin
                wptr_d[n] = wptr_q[n] + (addressWidth + 1)'(1);
            end else begin
                wptr_d[n] = wptr_q[n];
            end
            if (wptr_d[n] != NumWeightW) begin
                loaded_d = 1'b0;
            end
        end
        err_d = load_clr ? 1'b0 : (err_q | wr_err | start_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            raddr_q  <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            for (int n = 0; n < numNeurons; n++) begin
                wptr_q[n] <= '0;
            end
        end else begin
            state_q  <= state_d;
            raddr_q  <= raddr_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            valid_q  <= rd_issue;
            last_q   <= rd_issue && (raddr_q == LastAddr);
            for (int n = 0; n < numNeurons; n++) begin
                wptr_q[n] <= wptr_d[n];
            end
        end
    end

    // Per-neuron banks; the read register doubles as the held output value
    for (genvar n = 0; n < numNeurons; n++) begin : g_bank
        logic [dataWidth-1:0] mem [Depth];
        logic [dataWidth-1:0] rdata_q;

        always_ff @(posedge clk) begin
            if (bank_we[n]) begin
                mem[wptr_q[n][addressWidth-1:0]] <= wdata;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (rd_issue) begin
                rdata_q <= mem[raddr_q];
            end
        end

        assign wout[n*dataWidth +: dataWidth] = rdata_q;
    end

endmodule

// File: tb/tb_weight_stream_mem.sv
module tb_weight_stream_mem;

    localparam int NN = 2;
    localparam int NW = 4;
    localparam int AW = 2;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst, wen, load_clr, start, ren;
    logic [5:0]        wneuron;
    logic [DW-1:0]     wdata;
    logic [NN*DW-1:0]  wout;
    logic              wout_valid, wout_last, busy, loaded, load_err;

    weight_stream_mem #(
        .numNeurons  (NN),
        .numWeight   (NW),
        .addressWidth(AW),
        .dataWidth   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .wneuron   (wneuron),
        .wdata     (wdata),
        .load_clr  (load_clr),
        .start     (start),
        .ren       (ren),
        .wout      (wout),
        .wout_valid(wout_valid),
        .wout_last (wout_last),
        .busy      (busy),
        .loaded    (loaded),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NN*DW-1:0] data;
        logic             last;
        int               stamp;
    } beat_t;

    beat_t            sb[$];
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    logic             rst_at_edge = 1'b1;
    logic [NN*DW-1:0] held = '0;

    // Reference model: memory contents, write counts and flags
    logic [DW-1:0]    m_mem [NN][NW];
    int               m_wptr [NN];
    logic             m_loaded, m_err;
    logic [DW-1:0]    va [NW];
    logic [DW-1:0]    vb [NW];

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every valid beat
    always @(negedge clk) begin
        beat_t e;
        if (rst_at_edge) begin
            check("reset_wout", wout, '0);
            check("reset_valid", wout_valid, 1'b0);
            held = '0;
        end else if (wout_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got wout=0x%0h expected no beat (cycle %0d)",
                         wout, cyc);
            end else begin
                e = sb.pop_front();
                check("beat_data", wout, e.data);
                check("beat_last", wout_last, e.last);
                check("beat_cycle", cyc, e.stamp);
            end
            held = wout;
        end else begin
            check("wout_hold", wout, held);
            check("last_without_valid", wout_last, 1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic m_all_full();
        for (int n = 0; n < NN; n++) begin
            if (m_wptr[n] != NW) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [NN*DW-1:0] m_beat(input int i);
        logic [NN*DW-1:0] v;
        for (int n = 0; n < NN; n++) v[n*DW +: DW] = m_mem[n][i];
        return v;
    endfunction

    task automatic m_reset_ptrs();
        for (int n = 0; n < NN; n++) m_wptr[n] = 0;
        m_loaded = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] nb, input logic [DW-1:0] d, input logic clr);
        int idx;
        idx      = int'(nb);
        wen      = 1'b1;
        wneuron  = nb;
        wdata    = d;
        load_clr = clr;
        if (clr) begin
            m_reset_ptrs();
        end else if (idx < NN && m_wptr[idx] < NW) begin
            m_mem[idx][m_wptr[idx]] = d;
            m_wptr[idx]++;
        end else begin
            m_err = 1'b1;
        end
        step();
        wen      = 1'b0;
        load_clr = 1'b0;
        m_loaded = m_all_full();
        check("loaded_after_write", loaded, m_loaded);
        check("load_err_after_write", load_err, m_err);
    endtask

    task automatic clear_op();
        load_clr = 1'b1;
        m_reset_ptrs();
        step();
        load_clr = 1'b0;
        check("loaded_after_clr", loaded, 1'b0);
        check("load_err_after_clr", load_err, 1'b0);
    endtask

    task automatic load_vals();
        for (int i = 0; i < NW; i++) begin
            do_write(6'd0, va[i], 1'b0);
            do_write(6'd1, vb[i], 1'b0);
        end
    endtask

    // ren follows pat[0..plen-1], then stays high; inj_at injects a write and a start
    task automatic run_pass(input logic [15:0] pat, input int plen, input int inj_at);
        int    issued;
        int    e;
        logic  go;
        beat_t b;
        issued = 0;
        e      = 0;
        go     = m_loaded;
        if (!go) m_err = 1'b1;
        start = 1'b1;
        ren   = 1'b0;
        step();
        start = 1'b0;
        check("busy_after_start", busy, go);
        check("load_err_after_start", load_err, m_err);
        if (go) begin
            while (issued < NW) begin
                ren = (e < plen) ? pat[e] : 1'b1;
                if (e == inj_at) begin
                    wen     = 1'b1;
                    wneuron = 6'd0;
                    wdata   = 16'h5555;
                    start   = 1'b1;
                    m_err   = 1'b1;
                end
                if (ren) begin
                    b.data  = m_beat(issued);
                    b.last  = (issued == NW - 1);
                    b.stamp = cyc + 1;
                    sb.push_back(b);
                    issued++;
                end
                e++;
                step();
                wen   = 1'b0;
                start = 1'b0;
            end
            ren = 1'b0;
            check("busy_on_last", busy, 1'b1);
            check("load_err_in_pass", load_err, m_err);
            step();
            check("busy_after_last", busy, 1'b0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        beat_t b;
        rst = 1'b1; wen = 1'b0; load_clr = 1'b0; start = 1'b0; ren = 1'b0;
        wneuron = '0; wdata = '0;
        m_reset_ptrs();
        step();
        step();
        rst = 1'b0;
        check("rst_wout", wout, '0);
        check("rst_valid", wout_valid, 1'b0);
        check("rst_last", wout_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_loaded", loaded, 1'b0);
        check("rst_load_err", load_err, 1'b0);

        // Load and stream
        for (int i = 0; i < NW; i++) begin
            va[i] = DW'(i + 1);
            vb[i] = -DW'(i + 1);
        end
        load_vals();
        run_pass(16'h0, 0, -1);
        step();

        // Backpressure: ren 1,0,0,1,1,0,1
        run_pass(16'b1011001, 7, -1);
        step();

        // Errors
        do_write(6'd0, 16'h00AA, 1'b0);
        do_write(6'd3, 16'h0BAD, 1'b0);
        clear_op();
        for (int i = 0; i < NW; i++) do_write(6'd0, va[i], 1'b0);
        for (int i = 0; i < NW - 1; i++) do_write(6'd1, vb[i], 1'b0);
        run_pass(16'h0, 0, -1);
        for (int i = 0; i < 3; i++) step();
        check("load_err_sticky", load_err, m_err);
        check("busy_after_bad_start", busy, 1'b0);
        do_write(6'd1, vb[NW-1], 1'b0);

        // Write and second start during a pass
        clear_op();
        load_vals();
        run_pass(16'h0, 0, 1);
        step();

        // Reset after beat 2
        start = 1'b1;
        step();
        start = 1'b0;
        ren   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b.data  = m_beat(i);
            b.last  = 1'b0;
            b.stamp = cyc + 1;
            sb.push_back(b);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        ren = 1'b0;
        m_reset_ptrs();
        check("midrst_wout", wout, '0);
        check("midrst_valid", wout_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_loaded", loaded, 1'b0);
        check("midrst_load_err", load_err, 1'b0);
        step();
        step();
        for (int i = 0; i < NW; i++) begin
            va[i] = 16'h0009;
            vb[i] = 16'h0007;
        end
        load_vals();
        run_pass(16'h0, 0, -1);

        // load_clr beats a simultaneous write
        do_write(6'd3, 16'h0BAD, 1'b0);
        do_write(6'd0, 16'h1234, 1'b1);
        load_vals();
        run_pass(16'($urandom), 8, -1);

        // Randomized loads and ren patterns
        for (int r = 0; r < 6; r++) begin
            clear_op();
            for (int k = 0; k < 200 && !m_loaded; k++) begin
                if ($urandom_range(0, 7) == 0)
                    do_write(6'($urandom_range(2, 63)), 16'($urandom), 1'b0);
                else
                    do_write(6'($urandom_range(0, NN - 1)), 16'($urandom), 1'b0);
            end
            run_pass(16'($urandom), int'($urandom_range(0, 10)),
                     (r % 2 == 0) ? -1 : 2);
            step();
        end

        for (int i = 0; i < 3; i++) step();
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
